// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7..10).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  state_e        state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          multi, accept, done, idle;

  logic          signed_op;
  logic [63:0]   prod, res;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
`ifdef MDU_MADD_EN
    multi = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                       OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    multi = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`endif
    idle   = (state == S_IDLE);
    accept = start && idle && multi;
    done   = (state == S_BUSY) && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_BUSY;
      S_BUSY:  if (done)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_BUSY);
    stall_req = (state == S_BUSY) | (start & multi);
  end

  // Division works on magnitudes so INT_MIN / -1 wraps to INT_MIN naturally.
  always_comb begin
    signed_op = op_q inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    prod  = signed_op ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                      : ({32'b0, a_q} * {32'b0, b_q});
    a_mag = (signed_op && a_q[31]) ? -a_q : a_q;
    b_mag = (signed_op && b_q[31]) ? -b_q : b_q;
    q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    quo   = (signed_op && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    rem   = (signed_op && a_q[31]) ? -r_mag : r_mag;
    res   = {hi, lo};
    case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_DIV, OP_DIVU:   if (b_q != '0) res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
`endif
      default:           res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= rs_val;
        b_q  <= rt_val;
        cnt  <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        {hi, lo} <= res;
      end else if (start && idle && op == OP_MTHI) begin
        hi <= rs_val;
      end else if (start && idle && op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized scoreboard bench for e_mdu against an arithmetic HI/LO reference model.
// Honours MDU_MADD_EN the same way as the design.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_left = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;
  logic [63:0] pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb_, q, r;
    logic [63:0] ua, ub, sprod, uprod;
    sa = $signed(a);
    sb_ = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    sprod = sa * sb_;
    uprod = ua * ub;
    case (o)
      4'd1: return sprod;
      4'd2: return uprod;
      4'd3: begin
        if (b == 0) return acc;
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 0) return acc;
        return {(ua % ub) & 64'hFFFFFFFF, 32'b0} | ((ua / ub) & 64'hFFFFFFFF);
      end
      4'd7:  return acc + sprod;
      4'd8:  return acc + uprod;
      4'd9:  return acc - sprod;
      4'd10: return acc - uprod;
      default: return acc;
    endcase
  endfunction

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic st, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = st; op = o; rs_val = a; rt_val = b;
    #1;
    check("stall_req", stall_req, (busy_left > 0) || (st && is_multi(o)));
    check("busy", busy, busy_left > 0);
    check("hi", hi, cur_hi);
    check("lo", lo, cur_lo);
    @(posedge clk);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        cur_hi = pend[63:32];
        cur_lo = pend[31:0];
      end
    end else if (st) begin
      if (is_multi(o)) begin
        pend = model(o, a, b, {cur_hi, cur_lo});
        busy_left = (o == 4'd3 || o == 4'd4) ? DIV_N : MULT_N;
        sb.push_back('{pend[63:32], pend[31:0], busy_left});
      end else if (o == 4'd5) begin
        cur_hi = a;
      end else if (o == 4'd6) begin
        cur_lo = a;
      end
    end
    #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, '0, '0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy_left > 0; i++) cycle(1'b0, 4'd0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    busy_left = 0;
    cur_hi = '0;
    cur_lo = '0;
    sb.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 9);
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: each busy window that ends without reset retires one entry.
  logic prev_busy = 1'b0, prev_reset = 1'b1;
  int   busy_len = 0;
  exp_t e;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_len++;
      if (busy_len == 64) begin
        checks++;
        errors++;
        $display("FAIL busy_timeout: got busy for %0d cycles expected at most %0d", busy_len, DIV_N);
      end
    end else if (prev_busy === 1'b1) begin
      if (prev_reset !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got completion expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
          check("sb_busy_len", busy_len, e.cycles);
        end
      end
      busy_len = 0;
    end
    prev_busy = busy;
    prev_reset = reset;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    idle_cycles(2);

    cycle(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFF1);

    cycle(1'b1, 4'd4, 32'd7, 32'd2);
    wait_idle();
    check("t2u_lo", lo, 32'd3);
    check("t2u_hi", hi, 32'd1);
    cycle(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("t2s_lo", lo, 32'hFFFF_FFFD);
    check("t2s_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    cycle(1'b1, 4'd1, 32'd3, 32'd4);
    idle_cycles(1);
    cycle(1'b1, 4'd4, 32'd9, 32'd3);
    wait_idle();
    check("t3_hi", hi, 32'h0);
    check("t3_lo", lo, 32'd12);

    cycle(1'b1, 4'd5, 32'h11, '0);
    cycle(1'b1, 4'd6, 32'h22, '0);
    cycle(1'b1, 4'd3, 32'd100, 32'd0);
    wait_idle();
    check("t4_hi", hi, 32'h11);
    check("t4_lo", lo, 32'h22);

    cycle(1'b1, 4'd5, 32'hABCD_0000, '0);
    cycle(1'b1, 4'd6, 32'h0000_1234, '0);
    #1;
    check("t5_hi", hi, 32'hABCD_0000);
    check("t5_lo", lo, 32'h0000_1234);
    check("t5_busy", busy, 1'b0);
    idle_cycles(1);

    cycle(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
    idle_cycles(2);
    do_reset();
    check("t6_busy", busy, 1'b0);
    check("t6_hi", hi, 32'h0);
    check("t6_lo", lo, 32'h0);
    idle_cycles(8);

`ifdef MDU_MADD_EN
    cycle(1'b1, 4'd5, 32'h0, '0);
    cycle(1'b1, 4'd6, 32'h1, '0);
    cycle(1'b1, 4'd7, 32'd2, 32'd3);
    wait_idle();
    check("madd_lo", lo, 32'd7);
    cycle(1'b1, 4'd10, 32'd1, 32'd8);
    wait_idle();
    check("msubu_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    cycle(1'b1, 4'd7, 32'd2, 32'd3);
    cycle(1'b1, 4'd9, 32'd2, 32'd3);
    idle_cycles(2);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick());
    end
    wait_idle();
    idle_cycles(3);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
